// File: rtl/song_sequencer_pkg.sv
// Shared defaults, song entry layout and sequencer state encoding.
package song_sequencer_pkg;
  localparam int unsigned NOTE_BITS_DEF = 6;
  localparam int unsigned BEAT_BITS_DEF = 7;
  // Duration occupies the low bits of a song entry; the note sits directly above it.
  localparam int unsigned DUR_LSB       = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DONE
  } seq_state_t;
endpackage

// File: rtl/song_sequencer_beat_timer.sv
// Tempo divider: counts enabled clock ticks and flags the last tick of each beat.
module song_sequencer_beat_timer #(
  parameter int unsigned TICKS_PER_BEAT = 6000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic beat_c
);
  localparam int unsigned TICK_BITS = $clog2(TICKS_PER_BEAT);
  localparam logic [TICK_BITS-1:0] LAST_TICK = TICK_BITS'(TICKS_PER_BEAT - 1);

  logic [TICK_BITS-1:0] tick_cnt;

  assign beat_c = en && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= beat_c ? '0 : tick_cnt + TICK_BITS'(1);
    end
  end
endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM, issuing one new_note per entry followed by its duration in new_beat pulses.
module song_sequencer
  import song_sequencer_pkg::*;
#(
  parameter int unsigned NOTE_BITS      = NOTE_BITS_DEF,
  parameter int unsigned BEAT_BITS      = BEAT_BITS_DEF,
  parameter int unsigned SONG_ADDR_BITS = 7,
  parameter int unsigned SONG_LENGTH    = 128,
  parameter int unsigned TICKS_PER_BEAT = 6000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          play,
  output logic                          song_rd_en,
  output logic [SONG_ADDR_BITS-1:0]     song_addr,
  input  logic [NOTE_BITS+BEAT_BITS-1:0] song_data,
  output logic                          new_note,
  output logic [NOTE_BITS-1:0]          note,
  output logic [BEAT_BITS-1:0]          duration,
  output logic                          new_beat,
  output logic                          busy,
  output logic                          done
);
  localparam logic [SONG_ADDR_BITS-1:0] LAST_ADDR = SONG_ADDR_BITS'(SONG_LENGTH - 1);

  seq_state_t           state;
  logic [BEAT_BITS-1:0] beats_left;
  logic [BEAT_BITS-1:0] data_dur;
  logic [NOTE_BITS-1:0] data_note;
  logic                 tick_en;
  logic                 tick_clr;
  logic                 beat_c;

  assign data_dur  = song_data[DUR_LSB +: BEAT_BITS];
  assign data_note = song_data[DUR_LSB + BEAT_BITS +: NOTE_BITS];

  // Tempo only advances while holding a note with play high; any other state restarts the beat.
  assign tick_en  = (state == S_HOLD) && play && !stop;
  assign tick_clr = (state != S_HOLD) || stop;

  song_sequencer_beat_timer #(
    .TICKS_PER_BEAT(TICKS_PER_BEAT)
  ) u_beat_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (tick_en),
    .clr   (tick_clr),
    .beat_c(beat_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      song_rd_en <= 1'b0;
      song_addr  <= '0;
      new_note   <= 1'b0;
      note       <= '0;
      duration   <= '0;
      new_beat   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beats_left <= '0;
    end else begin
      new_note   <= 1'b0;
      new_beat   <= 1'b0;
      song_rd_en <= 1'b0;
      if (stop) begin
        state      <= S_IDLE;
        song_addr  <= '0;
        note       <= '0;
        duration   <= '0;
        beats_left <= '0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state      <= S_FETCH;
              song_addr  <= '0;
              song_rd_en <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
            end
          end
          S_FETCH: state <= S_WAIT;
          S_WAIT: begin
            // A zero duration marks the end of the song and is never played.
            if (data_dur == '0) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              new_note   <= 1'b1;
              note       <= data_note;
              duration   <= data_dur;
              beats_left <= data_dur;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (beat_c) begin
              new_beat   <= 1'b1;
              beats_left <= beats_left - BEAT_BITS'(1);
              if (beats_left == BEAT_BITS'(1)) begin
                if (song_addr == LAST_ADDR) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state      <= S_FETCH;
                  song_addr  <= song_addr + SONG_ADDR_BITS'(1);
                  song_rd_en <= 1'b1;
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a 4-entry synchronous ROM and 4 ticks per beat.
module tb_song_sequencer;
  localparam int unsigned NB = 6;
  localparam int unsigned BB = 7;
  localparam int unsigned AB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          stop;
  logic          play;
  logic          song_rd_en;
  logic [AB-1:0] song_addr;
  logic [NB+BB-1:0] song_data = '0;
  logic          new_note;
  logic [NB-1:0] note;
  logic [BB-1:0] duration;
  logic          new_beat;
  logic          busy;
  logic          done;

  logic [NB+BB-1:0] rom [0:3];
  int passed = 0;
  int total  = 0;
  int note_cnt = 0;
  int beat_cnt = 0;
  int overlap  = 0;
  int cyc;
  int n0, b0;
  logic [AB-1:0] max_addr = '0;

  song_sequencer #(
    .NOTE_BITS(NB), .BEAT_BITS(BB), .SONG_ADDR_BITS(AB),
    .SONG_LENGTH(4), .TICKS_PER_BEAT(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .play(play),
    .song_rd_en(song_rd_en), .song_addr(song_addr), .song_data(song_data),
    .new_note(new_note), .note(note), .duration(duration),
    .new_beat(new_beat), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (song_rd_en) song_data <= rom[song_addr[1:0]];

  always @(negedge clk) begin
    if (new_note) note_cnt++;
    if (new_beat) beat_cnt++;
    if (new_note && new_beat) overlap++;
    if (song_rd_en && song_addr > max_addr) max_addr = song_addr;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // n-1 quiet cycles followed by a beat on the n-th cycle.
  task automatic beat_in(input int n, input string tag);
    for (int i = 1; i < n; i++) begin
      step();
      chk({tag, "_quiet"}, 32'(new_beat | new_note), 32'd0);
    end
    step();
    chk(tag, 32'(new_beat), 32'd1);
  endtask

  task automatic load(input logic [NB+BB-1:0] e0, input logic [NB+BB-1:0] e1,
                      input logic [NB+BB-1:0] e2, input logic [NB+BB-1:0] e3);
    rom[0] = e0; rom[1] = e1; rom[2] = e2; rom[3] = e3;
  endtask

  function automatic logic [NB+BB-1:0] ent(input int n, input int d);
    return {NB'(n), BB'(d)};
  endfunction

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; play = 1'b1;
    load(ent(27, 2), ent(28, 1), ent(0, 0), ent(0, 0));
    #12;
    chk("rst_rd_en", 32'(song_rd_en), 32'd0);
    chk("rst_addr", 32'(song_addr), 32'd0);
    chk("rst_pulses", 32'(new_note | new_beat), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_dur", 32'(duration), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Song with end marker: two notes then done.
    start = 1'b1; step(); start = 1'b0;
    chk("s1_rd_en_e0", 32'(song_rd_en), 32'd1);
    chk("s1_addr_e0", 32'(song_addr), 32'd0);
    chk("s1_busy", 32'(busy), 32'd1);
    step();
    chk("s1_rd_en_e1", 32'(song_rd_en), 32'd0);
    chk("s1_no_note_e1", 32'(new_note), 32'd0);
    step();
    chk("s1_new_note_e2", 32'(new_note), 32'd1);
    chk("s1_note", 32'(note), 32'd27);
    chk("s1_dur", 32'(duration), 32'd2);
    beat_in(4, "s1_beat1");
    beat_in(4, "s1_beat2");
    chk("s1_fetch1_rd", 32'(song_rd_en), 32'd1);
    chk("s1_fetch1_addr", 32'(song_addr), 32'd1);
    step();
    chk("s1_wait1", 32'(new_note), 32'd0);
    step();
    chk("s1_new_note2", 32'(new_note), 32'd1);
    chk("s1_note2", 32'(note), 32'd28);
    chk("s1_dur2", 32'(duration), 32'd1);
    beat_in(4, "s1_beat3");
    chk("s1_fetch2_addr", 32'(song_addr), 32'd2);
    step(); step();
    chk("s1_end_done", 32'(done), 32'd1);
    chk("s1_end_busy", 32'(busy), 32'd0);
    chk("s1_end_no_note", 32'(new_note), 32'd0);
    chk("s1_end_note_held", 32'(note), 32'd28);
    step(); step();
    chk("s1_done_held", 32'(done), 32'd1);

    // Full ROM, no end marker: finishes after address 3.
    load(ent(1, 1), ent(2, 1), ent(3, 1), ent(4, 1));
    n0 = note_cnt;
    start = 1'b1; step(); start = 1'b0;
    chk("s2_done_cleared", 32'(done), 32'd0);
    cyc = 0;
    while (!done && cyc < 100) begin
      step();
      cyc++;
    end
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_done_cycle", 32'(cyc), 32'd24);
    chk("s2_note_count", 32'(note_cnt - n0), 32'd4);
    chk("s2_last_note", 32'(note), 32'd4);
    chk("s2_max_addr", 32'(max_addr), 32'd3);

    // Pause two cycles inside HOLD delays the first beat by two cycles.
    load(ent(5, 3), ent(0, 0), ent(0, 0), ent(0, 0));
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("s3_note", 32'(note), 32'd5);
    play = 1'b0;
    step(); chk("s3_pause1", 32'(new_beat), 32'd0);
    step(); chk("s3_pause2", 32'(new_beat), 32'd0);
    play = 1'b1;
    beat_in(4, "s3_beat1_delayed");
    beat_in(4, "s3_beat2");
    chk("s3_still_busy", 32'(busy), 32'd1);
    beat_in(4, "s3_beat3");
    chk("s3_fetch_addr", 32'(song_addr), 32'd1);
    step(); step();
    chk("s3_done", 32'(done), 32'd1);

    // Stop mid-HOLD, then replay from address 0; start while busy is ignored.
    load(ent(9, 3), ent(0, 0), ent(0, 0), ent(0, 0));
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("s4_note", 32'(note), 32'd9);
    beat_in(4, "s4_beat1");
    step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("s4_stop_busy", 32'(busy), 32'd0);
    chk("s4_stop_done", 32'(done), 32'd0);
    chk("s4_stop_note", 32'(note), 32'd0);
    chk("s4_stop_dur", 32'(duration), 32'd0);
    chk("s4_stop_beat", 32'(new_beat), 32'd0);
    n0 = note_cnt; b0 = beat_cnt;
    repeat (12) step();
    chk("s4_no_pulses", 32'((note_cnt - n0) + (beat_cnt - b0)), 32'd0);
    chk("s4_idle_busy", 32'(busy), 32'd0);
    start = 1'b1; step(); start = 1'b0;
    chk("s4_replay_rd", 32'(song_rd_en), 32'd1);
    chk("s4_replay_addr", 32'(song_addr), 32'd0);
    step(); step();
    chk("s4_replay_note", 32'(new_note), 32'd1);
    chk("s4_replay_val", 32'(note), 32'd9);
    start = 1'b1; step(); start = 1'b0;
    chk("s4_busy_start_rd", 32'(song_rd_en), 32'd0);
    chk("s4_busy_start_busy", 32'(busy), 32'd1);
    beat_in(3, "s4_busy_start_beat");
    stop = 1'b1; step(); stop = 1'b0;
    chk("s4_stop2_busy", 32'(busy), 32'd0);

    // start and stop together from IDLE: stop wins.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_rd", 32'(song_rd_en), 32'd0);
    step();
    chk("s5_rd_later", 32'(song_rd_en), 32'd0);

    // Asynchronous reset between edges while holding a note.
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    chk("s6_pre_note", 32'(new_note), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("s6_async_note", 32'(new_note), 32'd0);
    chk("s6_async_busy", 32'(busy), 32'd0);
    chk("s6_async_val", 32'(note), 32'd0);
    chk("s6_async_dur", 32'(duration), 32'd0);
    #2 rst = 1'b1;
    step();
    chk("s6_after_busy", 32'(busy), 32'd0);
    chk("s6_after_rd", 32'(song_rd_en), 32'd0);
    chk("s6_after_done", 32'(done), 32'd0);
    n0 = note_cnt; b0 = beat_cnt;
    repeat (6) step();
    chk("s6_quiet", 32'((note_cnt - n0) + (beat_cnt - b0)), 32'd0);

    chk("never_overlap", 32'(overlap), 32'd0);
    chk("addr_bound", 32'(max_addr), 32'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
